// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation codes, FSM state
// encodings and default datapath sizes.
package shift_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int SHIFT_SHW   = 5;

  // Code 2'b11 is reserved and is executed as a logical right shift.
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shift_ctrl_if.sv
// Issue/result bundle between the pipeline (master) and the iterative shifter
// (slave).
interface iter_shift_ctrl_if
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = SHIFT_SHW
);

  logic             start;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] data_in;
  logic             flush;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output start, op, shamt, data_in, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, op, shamt, data_in, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/shift_step_one.sv
// Single one-bit shift stage shared by all operations; the controller feeds
// its own register back through this stage once per clock.
module shift_step_one
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  // Left shift fills with zero; arithmetic right keeps the sign bit; logical
  // right (and the reserved code) fills the MSB with zero.
  always_comb begin
    data_o = {1'b0, data_i[WIDTH-1:1]};
    case (op_i)
      SHIFT_SLL: data_o = {data_i[WIDTH-2:0], 1'b0};
      SHIFT_SRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default:   data_o = {1'b0, data_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shifter: SLL/SRL/SRA by 0..WIDTH-1 places, one bit per clock.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; in_ready high
//   ST_SHIFT | one bit per edge, count_q holds remaining steps
//   ST_DONE  | result held on out_valid until out_ready (or flush)
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = SHIFT_SHW
) (
  input  logic             clock,
  input  logic             resetn,
  iter_shift_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] step_data;

  shift_step_one #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .data_o (step_data)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= SHIFT_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath update; flush always wins over start/out_ready.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          count_d = '0;
        end else if (bus.start) begin
          data_d  = bus.data_in;
          op_d    = bus.op;
          count_d = bus.shamt;
          state_d = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q != '0) begin
          data_d  = step_data;
          count_d = count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          // Unreachable with a consistent count; recover rather than stall.
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decode directly from the state register, so they are glitch-free
  // and the result only changes on a shift edge or a new accept.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.result    = data_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Bench for iter_shift_ctrl: vector table plus random operations checked
// through a result scoreboard, then hand-written flush/backpressure/reset
// sequences.
module tb_iter_shift_ctrl;

  localparam int W = 32;
  localparam int S = 5;

  typedef struct {
    logic [1:0]   op;
    logic [S-1:0] shamt;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } sb_t;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;
  sb_t  sb_q[$];
  vec_t vecs[10];

  iter_shift_ctrl_if #(.WIDTH(W), .SHW(S)) bus ();

  iter_shift_ctrl #(.WIDTH(W), .SHW(S)) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [S-1:0] s,
                                          input logic [W-1:0] d);
    case (op)
      2'b00:   return d << s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d >> s;
    endcase
  endfunction

  // Wait (bounded) for in_ready, present one request, push the expectation.
  // Returns at the negedge following the accepting edge with start dropped.
  task automatic issue(input logic [1:0] op, input logic [S-1:0] s, input logic [W-1:0] d,
                       input logic [W-1:0] exp);
    int n;
    sb_t e;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("issue_in_ready", 32'(bus.in_ready), 32'd1);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.shamt   = s;
    bus.data_in = d;
    e.res = exp;
    e.lat = int'(s);
    sb_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Measure latency to out_valid, compare against the scoreboard head,
  // optionally hold backpressure, then hand the result off.
  task automatic collect(input int hold);
    int lat;
    logic busy_bad;
    sb_t e;
    lat = 0;
    busy_bad = 1'b0;
    if (!bus.busy) busy_bad = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
      if (!bus.busy) busy_bad = 1'b1;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("busy_during_op", 32'(busy_bad), 32'd0);
    chk("result", bus.result, e.res);
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [S-1:0] rs;
    logic [W-1:0] rd;
    logic         bad;

    checks   = 0;
    failures = 0;
    vecs[0] = '{2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000};
    vecs[1] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[2] = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[3] = '{2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{2'b11, 5'd4,  32'hF000_0000, 32'h0F00_0000};
    vecs[5] = '{2'b00, 5'd4,  32'h0000_000F, 32'h0000_00F0};
    vecs[6] = '{2'b10, 5'd1,  32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[7] = '{2'b10, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF};
    vecs[8] = '{2'b01, 5'd16, 32'hDEAD_BEEF, 32'h0000_DEAD};
    vecs[9] = '{2'b00, 5'd8,  32'hDEAD_BEEF, 32'hADBE_EF00};

    bus.start = 1'b0; bus.op = 2'b00; bus.shamt = '0; bus.data_in = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_result",    bus.result,         32'd0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].shamt, vecs[i].data, vecs[i].exp);
      collect(0);
    end

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 31));
      rd  = $urandom;
      issue(rop, rs, rd, model(rop, rs, rd));
      collect(0);
    end

    // Backpressure with ignored start pulses while DONE.
    issue(2'b10, 5'd2, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
    repeat (2) @(negedge clock);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.start   = (i % 2 == 0);
      bus.data_in = 32'h5555_5555;
      bus.shamt   = 5'd0;
      if (!bus.out_valid || bus.result !== 32'hFFFF_FFFC || bus.in_ready) bad = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    bus.start = 1'b0;
    chk("bp_held", 32'(bad), 32'd0);
    chk("bp_result", bus.result, 32'hFFFF_FFFC);
    void'(sb_q.pop_front());
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("bp_in_ready_next", 32'(bus.in_ready), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.out_valid || !bus.in_ready) bad = 1'b1;
    end
    chk("bp_start_not_queued", 32'(bad), 32'd0);

    // Flush on the third SHIFT cycle of a 10-step operation.
    issue(2'b01, 5'd10, 32'hFFFF_0000, 32'h003F_FFC0);
    void'(sb_q.pop_front());
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    bus.flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_shift_idle", 32'(bus.in_ready), 32'd1);
    chk("flush_shift_busy", 32'(bus.busy), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) bad = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    chk("flush_shift_no_valid", 32'(bad), 32'd0);

    // flush and start together in IDLE: request is refused.
    bus.flush = 1'b1; bus.start = 1'b1; bus.shamt = 5'd0; bus.data_in = 32'hA5A5_A5A5;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_idle_not_accepted", 32'(bus.busy), 32'd0);
    chk("flush_idle_no_valid", 32'(bus.out_valid), 32'd0);

    // flush together with out_ready in DONE drops the result.
    issue(2'b00, 5'd1, 32'h0000_0003, 32'h0000_0006);
    void'(sb_q.pop_front());
    @(posedge clock);
    @(negedge clock);
    chk("flush_done_valid_before", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    chk("flush_done_idle", 32'(bus.in_ready), 32'd1);
    chk("flush_done_no_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges in the middle of SHIFT.
    issue(2'b01, 5'd20, 32'h0000_0100, 32'h0);
    void'(sb_q.pop_front());
    repeat (3) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy",      32'(bus.busy),      32'd0);
    chk("arst_result",    bus.result,         32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    issue(2'b01, 5'd8, 32'h0000_0100, 32'h0000_0001);
    collect(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
